debug_frame_tx: RTL
===================

Name: debug_frame_tx

Overview:
- Parametrised successor to the pipeline-snapshot packer: captures an arbitrary-width debug frame (PC, instruction, control, register file, hazard signals) into a shadow register on request.
- Streams the frame out byte-serially to the UART transmitter over a valid/ready handshake, framed by a header byte and followed by an optional XOR checksum byte.
- Sits between the processor debug taps and the UART TX.

Parameters:
- N_BITS, 1208, payload width in bits; N_BYTES = ceil(N_BITS/8).
- HEADER, 8'hA5, start-of-frame byte sent before the payload.
- CHECKSUM_EN, 1, 1 = append an XOR checksum byte after the payload; 0 = omit it.
- CNT_W, 8, byte-index counter width; must satisfy 2^CNT_W >= N_BYTES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- snap_req  in  1  capture frame_in and start transmission.
- frame_in  in  N_BITS  debug snapshot, packed LSB-first.
- abort  in  1  cancel the frame in progress.
- tx_ready  in  1  UART TX can accept a byte.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_data  out  8  byte to transmit.
- busy  out  1  a frame is being sent.
- done  out  1  one-cycle pulse: frame completed.
- overrun  out  1  one-cycle pulse: snap_req dropped.

Behaviour:
- Reset (async, active-high): state=IDLE; tx_valid=0, tx_data=0, busy=0, done=0, overrun=0; shadow=0, byte index=0, checksum=0. Reset mid-frame stops transmission immediately; no further bytes are sent.
- All outputs are registered.
- States: IDLE, HDR, PAY, CHK, DONE.
- IDLE or DONE with snap_req=1 at edge t:
  - shadow <= frame_in, zero-padded to 8*N_BYTES.
  - idx <= 0, chk <= 0.
  - state <= HDR, tx_valid <= 1, tx_data <= HEADER, busy <= 1.
  - First byte is therefore offered one cycle after the request.
- Byte transfer occurs on any edge with tx_valid && tx_ready. While tx_valid=1 && tx_ready=0, tx_data holds stable.
- HDR, transfer: state <= PAY; tx_data <= shadow byte 0.
- PAY, transfer of byte idx (byte k = shadow[8k+7:8k]):
  - chk <= chk ^ byte idx.
  - If idx < N_BYTES-1: idx++, tx_data <= byte idx+1.
  - Else if CHECKSUM_EN=1: state <= CHK, tx_data <= chk ^ byte idx.
  - Else: state <= DONE.
- CHK, transfer: state <= DONE.
- Entry to DONE: tx_valid <= 0, busy <= 0, done <= 1 for exactly one cycle. DONE goes to IDLE next cycle unless snap_req is accepted.
- snap_req while in HDR, PAY or CHK: ignored; shadow is not disturbed; overrun <= 1 for one cycle.
- abort=1 in HDR, PAY or CHK:
  - state <= IDLE at the next edge; tx_valid <= 0, busy <= 0; done is not pulsed.
  - abort takes priority over a simultaneous transfer.
  - abort in IDLE or DONE has no effect.
- Simultaneous abort and snap_req in a busy state: abort wins, overrun pulses, and the request is not latched.
- N_BITS not a multiple of 8: the top byte is zero-padded, and the padding participates in the checksum.
- Total bytes per frame = 1 + N_BYTES + CHECKSUM_EN. Default N_BITS=1208 gives 1 + 151 + 1 = 153 bytes.

Test Plan:
1. N_BITS=16, HEADER=A5, frame_in=16'hA55A, tx_ready tied 1, snap_req pulse -> bytes A5,5A,A5,FF on 4 consecutive cycles; done pulses on the cycle after FF; busy=0 thereafter.
2. N_BITS=20, frame_in=20'hF1234, CHECKSUM_EN=0, tx_ready=1 -> bytes A5,34,12,0F; no checksum byte; done pulses once.
3. Test-1 setup with tx_ready=0 for 5 cycles during byte 5A -> tx_data holds 5A with tx_valid=1 throughout; stream resumes unchanged when ready rises.
4. snap_req pulse mid-frame with a different frame_in -> overrun pulses for 1 cycle; transmitted bytes match the original capture.
5. abort during PAY after 2 bytes accepted -> tx_valid=0 next cycle, busy=0, no done; a new snap_req then produces a full correct frame starting with A5.
6. Reset asserted asynchronously between edges mid-frame -> tx_valid, busy and done go 0 immediately; after release, IDLE; default N_BITS=1208 frame of all-ones -> 153 bytes, checksum 8'hFF.

Source files
------------

// File: rtl/debug_frame_tx_if.sv
// Byte stream from the debug frame packer to the UART transmitter.
interface debug_frame_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/debug_frame_tx.sv
// Debug frame transmitter: captures a wide snapshot into a shadow register and
// streams it byte-serially as HEADER, payload bytes LSB-first, optional XOR checksum.
module debug_frame_tx #(
  parameter int unsigned N_BITS      = 1208,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter bit          CHECKSUM_EN = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snap_req,
  input  logic [N_BITS-1:0] frame_in,
  input  logic              abort,
  debug_frame_tx_if.master  tx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned N_BYTES  = (N_BITS + 7) / 8;
  localparam int unsigned PAD_W    = 8 * N_BYTES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_CHK,
    ST_DONE
  } state_t;

  state_t           state;
  logic [PAD_W-1:0] shadow;
  logic [CNT_W-1:0] idx;
  logic [7:0]       chk;
  logic [7:0]       cur_byte;
  logic [7:0]       nxt_byte;
  logic             xfer;

  // Payload byte currently offered and the one following it.
  always_comb begin
    cur_byte = 8'(shadow >> {idx, 3'b000});
    nxt_byte = 8'(shadow >> {idx + CNT_W'(1), 3'b000});
    xfer     = tx.tx_valid && tx.tx_ready;
  end

  // Frame sequencer with registered stream and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      shadow      <= '0;
      idx         <= '0;
      chk         <= 8'h00;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (snap_req) begin
            shadow      <= PAD_W'(frame_in);
            idx         <= '0;
            chk         <= 8'h00;
            state       <= ST_HDR;
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= HEADER;
            busy        <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          // A request while a frame is in flight is dropped and flagged.
          if (snap_req) begin
            overrun <= 1'b1;
          end
          if (abort) begin
            state       <= ST_IDLE;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
          end else if (xfer) begin
            case (state)
              ST_HDR: begin
                state      <= ST_PAY;
                tx.tx_data <= shadow[7:0];
              end
              ST_PAY: begin
                chk <= chk ^ cur_byte;
                if (idx != LAST_IDX) begin
                  idx        <= idx + CNT_W'(1);
                  tx.tx_data <= nxt_byte;
                end else if (CHECKSUM_EN) begin
                  state      <= ST_CHK;
                  tx.tx_data <= chk ^ cur_byte;
                end else begin
                  state       <= ST_DONE;
                  tx.tx_valid <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                end
              end
              ST_CHK: begin
                state       <= ST_DONE;
                tx.tx_valid <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
